// File: rtl/mem_bus_pkg.sv
// Shared constants for the MEM-stage bus arbiter: default widths, word size
// and the arbiter state encoding.
package mem_bus_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 32;
    localparam int LEN_W_DEF      = 4;
    localparam int STARVE_MAX_DEF = 4;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    localparam logic [0:0] OWN_CPU = 1'b0;
    localparam logic [0:0] OWN_DMA = 1'b1;

endpackage

// File: rtl/dma_beat_counter.sv
// Burst address generator: latches the word-aligned base and length when a
// burst is granted, advances one word per acknowledged beat, and flags the
// final beat.
module dma_beat_counter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;

    // Next-state: a load restarts the burst at beat 0, an ack advances it.
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        beat_d = beat_q;
        if (load) begin
            base_d = base_in & ~ADDR_W'(WORD_BYTES - 1);
            len_d  = len_in;
            beat_d = '0;
        end else if (inc) begin
            beat_d = beat_q + 1'b1;
        end
    end

    // Burst registers, cleared so a reset-aborted burst leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            beat_q <= beat_d;
        end
    end

    // Byte address of the current beat; wraps silently at the top of memory.
    always_comb begin
        addr = base_q + (ADDR_W'(beat_q) << WORD_SHIFT);
        last = (beat_q == len_q);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// MEM-stage bus arbiter between the pipeline (fixed priority) and the UART
// loader DMA. A starvation counter forces a DMA grant once the pipeline has
// kept the bus busy for STARVE_MAX consecutive requested cycles.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  OWN_CPU | pipeline drives the bus; DMA requests are arbitrated here
//  OWN_DMA | DMA burst in progress; pipeline memory accesses are stalled
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_MAX - 1);

    logic [0:0]          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wr_q, wr_d;

    logic              cpu_busy;
    logic              grant;
    logic              cnt_load;
    logic              cnt_inc;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last;

    assign cpu_busy = cpu_rd | cpu_wr;
    assign grant    = (state_q == OWN_CPU) && dma_req
                      && (!cpu_busy || (starve_q == STARVE_LAST));
    assign cnt_load = grant;
    assign cnt_inc  = (state_q == OWN_DMA) && dma_req;
    // Grant is a flop output, so the DMA never sees a combinational glitch.
    assign dma_gnt  = (state_q == OWN_DMA);

    dma_beat_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_beat_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .base_in (dma_addr),
        .len_in  (dma_len),
        .inc     (cnt_inc),
        .addr    (cnt_addr),
        .last    (cnt_last)
    );

    // Arbitration, starvation tracking and bus muxing from the current owner.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        wr_d      = wr_q;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        dma_ack   = 1'b0;
        dma_rdata = '0;
        dma_done  = 1'b0;

        if (state_q == OWN_CPU) begin
            bus_rd    = cpu_rd;
            bus_wr    = cpu_wr;
            bus_addr  = cpu_addr;
            bus_wdata = cpu_wdata;
            cpu_rdata = bus_rdata;
            if (grant) begin
                state_d  = OWN_DMA;
                starve_d = '0;
                wr_d     = dma_wr;
            end else if (dma_req) begin
                starve_d = starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end else begin
            bus_addr  = cnt_addr;
            bus_wdata = dma_wdata;
            bus_wr    = wr_q & dma_req;
            bus_rd    = ~wr_q & dma_req;
            dma_ack   = dma_req;
            dma_rdata = bus_rdata;
            // Only memory instructions collide with the burst.
            cpu_stall = cpu_busy;
            if (!dma_req) begin
                state_d = OWN_CPU;
            end else if (cnt_last) begin
                dma_done = 1'b1;
                state_d  = OWN_CPU;
            end
        end

        // Pipeline pass-through is combinational, so reset must mask it too.
        if (reset) begin
            bus_rd    = 1'b0;
            bus_wr    = 1'b0;
            bus_addr  = '0;
            bus_wdata = '0;
            cpu_rdata = '0;
            cpu_stall = 1'b0;
            dma_ack   = 1'b0;
            dma_rdata = '0;
            dma_done  = 1'b0;
        end
    end

    // Owner, starvation count and latched burst direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= OWN_CPU;
            starve_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wr_q     <= wr_d;
        end
    end

endmodule
